sweep_gen: RTL and testbench
============================

SWEEP_GEN -- requirements
Module: sweep_gen

Interface
REQ-001 SHALL have parameter DWELL_W, default 16, width of dwell count.
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start_word  in  32  first frequency control word of sweep.
REQ-005 SHALL have port stop_word  in  32  final frequency control word.
REQ-006 SHALL have port step_word  in  32  unsigned increment per step.
REQ-007 SHALL have port dwell  in  DWELL_W  cycles each word is held.
REQ-008 SHALL have port go  in  1  start request, one-cycle pulse or level.
REQ-009 SHALL have port abort  in  1  terminate sweep.
REQ-010 SHALL have port ctrl  out  32  registered frequency control word driving the NCO ctrl input.
REQ-011 SHALL have port busy  out  1  high while a sweep is active.
REQ-012 SHALL have port done  out  1  one-cycle pulse on normal completion.

Function
REQ-013 SHALL implement states IDLE, DWELL, DONE (plus DOWN when SWEEP_BIDIR_EN defined).
REQ-014 SHALL in IDLE with go=1 capture start/stop/step/dwell on that edge, set ctrl=start_word, busy=1, enter DWELL.
REQ-015 SHALL ignore go when not in IDLE; captured values SHALL NOT change mid-sweep.
REQ-016 SHALL hold each ctrl value for exactly max(dwell,1) cycles (dwell=0 treated as 1).
REQ-017 SHALL at dwell expiry: if ctrl==stop, or step==0, or start>=stop, go to DONE; else ctrl <= min(ctrl+step, stop), reload dwell counter.
REQ-018 SHALL compute ctrl+step at 33 bits; carry out SHALL clamp result to stop (no wrap-around).
REQ-019 SHALL in DONE drive done=1, busy=0 for one cycle, hold ctrl, return to IDLE on next edge.
REQ-020 SHALL in IDLE hold ctrl at last value; busy=0, done=0.
REQ-021 SHALL on abort=1 in DWELL/DOWN/DONE go to IDLE next edge with ctrl=0, busy=0, done=0; abort wins over go and dwell expiry.
REQ-022 SHALL have latency of one cycle from accepted go to ctrl=start_word and busy=1.

Reset
REQ-023 SHALL on rst=1 force state IDLE, ctrl=0, busy=0, done=0, dwell counter 0, regardless of state.
REQ-024 SHALL give rst priority over go and abort; a sweep interrupted by reset SHALL NOT resume.

Configuration
REQ-025 SHALL use macro SWEEP_BIDIR_EN.
REQ-026 SHALL when SWEEP_BIDIR_EN defined, on reaching stop enter DOWN, decrement by step per dwell, clamp at start (borrow clamps to start), then DONE: one up-down round trip.
REQ-027 SHALL when SWEEP_BIDIR_EN undefined omit DOWN state and subtractor; sweep is up-only per REQ-017.

Structure
REQ-028 SHALL place state enumeration and 32-bit control-word width constant in shared package mawg_pkg.
REQ-029 SHALL use one sub-module sweep_dwell_cnt: loadable down-counter, DWELL_W bits, expiry flag.

Verification
REQ-030 SHALL cover: start=100, stop=400, step=100, dwell=3, go -> ctrl 100,200,300,400 each 3 cycles, done pulse after 12 cycles, busy low.
REQ-031 SHALL cover: start=0, stop=250, step=100, dwell=1 -> ctrl 0,100,200,250 (clamped), then done.
REQ-032 SHALL cover: start=0xFFFFFF00, stop=0xFFFFFFFF, step=0x200 -> ctrl 0xFFFFFF00 then 0xFFFFFFFF, no wrap to small value.
REQ-033 SHALL cover: abort in second dwell of a sweep with concurrent go -> next cycle ctrl=0, busy=0, no done; later go restarts from start.
REQ-034 SHALL cover: rst asserted mid-sweep -> ctrl=0, busy=0, done=0 next edge; step=0 or dwell=0 -> single 1-cycle-or-dwell hold at start then done.
REQ-035 SHALL cover with SWEEP_BIDIR_EN: start=10, stop=30, step=10, dwell=1 -> ctrl 10,20,30,20,10, then done.

Source files
------------

// File: rtl/mawg_pkg.sv
// Shared types and constants for the frequency sweep generator.
// SWEEP_BIDIR_EN adds the DOWN state and the saturating subtractor.
package mawg_pkg;

   localparam int CTRL_W = 32;

`ifdef SWEEP_BIDIR_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DWELL = 2'd1,
      ST_DONE  = 2'd2,
      ST_DOWN  = 2'd3
   } sweep_state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DWELL = 2'd1,
      ST_DONE  = 2'd2
   } sweep_state_t;
`endif

   // Carry out of the 33-bit sum means overflow, which also clamps to the limit.
   function automatic logic [CTRL_W-1:0] sat_add(
      input logic [CTRL_W-1:0] a,
      input logic [CTRL_W-1:0] b,
      input logic [CTRL_W-1:0] limit
   );
      logic [CTRL_W:0]   sum;
      logic [CTRL_W-1:0] res;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[CTRL_W] || (sum[CTRL_W-1:0] > limit)) begin
         res = limit;
      end else begin
         res = sum[CTRL_W-1:0];
      end
      return res;
   endfunction

`ifdef SWEEP_BIDIR_EN
   function automatic logic [CTRL_W-1:0] sat_sub(
      input logic [CTRL_W-1:0] a,
      input logic [CTRL_W-1:0] b,
      input logic [CTRL_W-1:0] limit
   );
      logic [CTRL_W:0]   diff;
      logic [CTRL_W-1:0] res;
      diff = {1'b0, a} - {1'b0, b};
      if (diff[CTRL_W] || (diff[CTRL_W-1:0] < limit)) begin
         res = limit;
      end else begin
         res = diff[CTRL_W-1:0];
      end
      return res;
   endfunction
`endif

endpackage

// File: rtl/sweep_dwell_cnt.sv
// Loadable down-counter timing how long each control word is held.
// o_expired is high when the count has reached zero.
module sweep_dwell_cnt #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_clr,
   input  logic               i_load,
   input  logic [DWELL_W-1:0] i_load_val,
   input  logic               i_dec,
   output logic               o_expired
);

   logic [DWELL_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - DWELL_W'(1);
      end
   end

   assign o_expired = (r_count == '0);

endmodule

// File: rtl/sweep_gen.sv
// Stepped frequency sweep generator feeding an NCO control word.
// Define SWEEP_BIDIR_EN for an up-then-down round trip instead of up-only.
module sweep_gen
   import mawg_pkg::*;
#(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [CTRL_W-1:0]  start_word,
   input  logic [CTRL_W-1:0]  stop_word,
   input  logic [CTRL_W-1:0]  step_word,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               go,
   input  logic               abort,
   output logic [CTRL_W-1:0]  ctrl,
   output logic               busy,
   output logic               done
);

   sweep_state_t       r_state;
   logic [CTRL_W-1:0]  r_ctrl;
   logic               r_busy;
   logic               r_done;
   logic [CTRL_W-1:0]  r_start;
   logic [CTRL_W-1:0]  r_stop;
   logic [CTRL_W-1:0]  r_step;
   logic [DWELL_W-1:0] r_dwell;

   logic               w_expired;
   logic               w_cnt_load;
   logic               w_cnt_dec;
   logic               w_cnt_clr;
   logic [DWELL_W-1:0] w_dwell_src;
   logic [DWELL_W-1:0] w_load_val;
   logic               w_sweep_null;
   logic               w_at_stop;
   logic [CTRL_W-1:0]  w_up_next;
`ifdef SWEEP_BIDIR_EN
   logic               w_at_start;
   logic [CTRL_W-1:0]  w_dn_next;
`endif

   // A sweep with no step or an empty range holds start for one dwell, then ends.
   assign w_sweep_null = (r_step == '0) || (r_start >= r_stop);
   assign w_at_stop    = (r_ctrl == r_stop);
   assign w_up_next    = sat_add(r_ctrl, r_step, r_stop);
`ifdef SWEEP_BIDIR_EN
   assign w_at_start   = (r_ctrl == r_start);
   assign w_dn_next    = sat_sub(r_ctrl, r_step, r_start);
`endif

   // dwell=0 behaves as dwell=1: the counter holds max(dwell,1)-1.
   assign w_load_val = (w_dwell_src == '0) ? '0 : (w_dwell_src - DWELL_W'(1));

   always_comb begin
      w_cnt_load  = 1'b0;
      w_cnt_dec   = 1'b0;
      w_cnt_clr   = 1'b0;
      w_dwell_src = r_dwell;
      case (r_state)
         ST_IDLE: begin
            if (go) begin
               w_cnt_load  = 1'b1;
               w_dwell_src = dwell;
            end
         end
         ST_DWELL: begin
            if (abort) begin
               w_cnt_clr = 1'b1;
            end else if (w_expired) begin
`ifdef SWEEP_BIDIR_EN
               w_cnt_load = !w_sweep_null;
`else
               w_cnt_load = !(w_sweep_null || w_at_stop);
`endif
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
`ifdef SWEEP_BIDIR_EN
         ST_DOWN: begin
            if (abort) begin
               w_cnt_clr = 1'b1;
            end else if (w_expired) begin
               w_cnt_load = !w_at_start;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
`endif
         ST_DONE: begin
            w_cnt_clr = abort;
         end
         default: begin
            w_cnt_clr = 1'b1;
         end
      endcase
   end

   sweep_dwell_cnt #(
      .DWELL_W (DWELL_W)
   ) u_dwell_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_cnt_clr),
      .i_load     (w_cnt_load),
      .i_load_val (w_load_val),
      .i_dec      (w_cnt_dec),
      .o_expired  (w_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ctrl  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_start <= '0;
         r_stop  <= '0;
         r_step  <= '0;
         r_dwell <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (go) begin
                  r_start <= start_word;
                  r_stop  <= stop_word;
                  r_step  <= step_word;
                  r_dwell <= dwell;
                  r_ctrl  <= start_word;
                  r_busy  <= 1'b1;
                  r_state <= ST_DWELL;
               end
            end
            ST_DWELL: begin
               if (abort) begin
                  r_state <= ST_IDLE;
                  r_ctrl  <= '0;
                  r_busy  <= 1'b0;
               end else if (w_expired) begin
`ifdef SWEEP_BIDIR_EN
                  if (w_sweep_null) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else if (w_at_stop) begin
                     r_state <= ST_DOWN;
                     r_ctrl  <= w_dn_next;
                  end else begin
                     r_ctrl  <= w_up_next;
                  end
`else
                  if (w_sweep_null || w_at_stop) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_ctrl  <= w_up_next;
                  end
`endif
               end
            end
`ifdef SWEEP_BIDIR_EN
            ST_DOWN: begin
               if (abort) begin
                  r_state <= ST_IDLE;
                  r_ctrl  <= '0;
                  r_busy  <= 1'b0;
               end else if (w_expired) begin
                  if (w_at_start) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_ctrl  <= w_dn_next;
                  end
               end
            end
`endif
            ST_DONE: begin
               r_state <= ST_IDLE;
               if (abort) begin
                  r_ctrl <= '0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ctrl  <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign ctrl = r_ctrl;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_sweep_gen.sv
// Directed scoreboard bench for sweep_gen: expected per-cycle ctrl/busy/done
// are queued when a sweep is launched and popped one per clock.
module tb_sweep_gen;

   localparam int DW = 16;

   typedef struct packed {
      logic [31:0] ctrl;
      logic        busy;
      logic        done;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_i;
   logic [31:0]   start_i;
   logic [31:0]   stop_i;
   logic [31:0]   step_i;
   logic [DW-1:0] dwell_i;
   logic          go_i;
   logic          abort_i;
   logic [31:0]   ctrl_o;
   logic          busy_o;
   logic          done_o;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   sweep_gen #(.DWELL_W(DW)) dut (
      .clk        (clk),
      .rst        (rst_i),
      .start_word (start_i),
      .stop_word  (stop_i),
      .step_word  (step_i),
      .dwell      (dwell_i),
      .go         (go_i),
      .abort      (abort_i),
      .ctrl       (ctrl_o),
      .busy       (busy_o),
      .done       (done_o)
   );

   always #5 clk = ~clk;

   task automatic push(input logic [31:0] c, input int n, input logic b, input logic d);
      exp_t e;
      e.ctrl = c;
      e.busy = b;
      e.done = d;
      for (int i = 0; i < n; i++) sb_q.push_back(e);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
      end
   endtask

   // Drive one cycle of control inputs, then compare outputs 1 ns after the edge.
   task automatic cyc(input logic g, input logic a, input logic r, input string tag);
      exp_t e;
      go_i    = g;
      abort_i = a;
      rst_i   = r;
      @(posedge clk);
      #1;
      checks++;
      assert (sb_q.size() != 0) else begin
         failures++;
         $error("FAIL %s.queue observed=empty expected=entry", tag);
      end
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check({tag, ".ctrl"}, ctrl_o, e.ctrl);
         check({tag, ".busy"}, {31'd0, busy_o}, {31'd0, e.busy});
         check({tag, ".done"}, {31'd0, done_o}, {31'd0, e.done});
      end
   endtask

   task automatic set_cfg(input logic [31:0] s, input logic [31:0] p, input logic [31:0] st,
                          input logic [DW-1:0] d);
      start_i = s;
      stop_i  = p;
      step_i  = st;
      dwell_i = d;
   endtask

   // Go on the first cycle; optionally a stray go with junk words at junk_at.
   task automatic run_queue(input string tag, input int junk_at);
      int i;
      i = 0;
      while (sb_q.size() != 0 && i < 1000) begin
         if (i == junk_at) set_cfg(32'h0BAD_0BAD, 32'h0000_0001, 32'h7, 16'd9);
         cyc((i == 0) || (i == junk_at), 1'b0, 1'b0, tag);
         i++;
      end
      $display("sweep %s: %0d cycles compared", tag, i);
   endtask

   initial begin
      rst_i   = 1'b1;
      go_i    = 1'b0;
      abort_i = 1'b0;
      set_cfg(32'd0, 32'd0, 32'd0, 16'd0);

      // Reset, including go/abort asserted during reset
      push(32'd0, 3, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, "reset");
      set_cfg(32'd5, 32'd9, 32'd1, 16'd1);
      cyc(1'b1, 1'b1, 1'b1, "reset_prio");
      cyc(1'b0, 1'b0, 1'b0, "reset_idle");
      $display("sweep reset: %0d checks so far", checks);

      // 100..400 step 100, dwell 3, stray go mid-sweep
      set_cfg(32'd100, 32'd400, 32'd100, 16'd3);
      push(32'd100, 3, 1'b1, 1'b0);
      push(32'd200, 3, 1'b1, 1'b0);
      push(32'd300, 3, 1'b1, 1'b0);
      push(32'd400, 3, 1'b1, 1'b0);
      push(32'd400, 1, 1'b0, 1'b1);
      push(32'd400, 2, 1'b0, 1'b0);
      run_queue("basic", 5);

      // Last step clamped to stop
      set_cfg(32'd0, 32'd250, 32'd100, 16'd1);
      push(32'd0,   1, 1'b1, 1'b0);
      push(32'd100, 1, 1'b1, 1'b0);
      push(32'd200, 1, 1'b1, 1'b0);
      push(32'd250, 1, 1'b1, 1'b0);
      push(32'd250, 1, 1'b0, 1'b1);
      push(32'd250, 1, 1'b0, 1'b0);
      run_queue("clamp", -1);

      // 32-bit carry out must clamp, not wrap
      set_cfg(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h0000_0200, 16'd2);
      push(32'hFFFF_FF00, 2, 1'b1, 1'b0);
      push(32'hFFFF_FFFF, 2, 1'b1, 1'b0);
      push(32'hFFFF_FFFF, 1, 1'b0, 1'b1);
      push(32'hFFFF_FFFF, 1, 1'b0, 1'b0);
      run_queue("carry", -1);

      // Abort with concurrent go in the second dwell, then restart from start
      set_cfg(32'd5, 32'd50, 32'd5, 16'd3);
      push(32'd5,  3, 1'b1, 1'b0);
      push(32'd10, 1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, "abort_run");
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, "abort_run");
      push(32'd0, 1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, "abort_hit");
      push(32'd0, 2, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, "abort_idle");
      cyc(1'b0, 1'b0, 1'b0, "abort_idle");
      push(32'd5,  3, 1'b1, 1'b0);
      push(32'd10, 1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, "abort_restart");
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, "abort_restart");
      push(32'd0, 1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, "abort_again");
      $display("sweep abort: %0d checks so far", checks);

      // Reset mid-sweep; sweep must not resume
      set_cfg(32'd100, 32'd400, 32'd100, 16'd2);
      push(32'd100, 2, 1'b1, 1'b0);
      push(32'd200, 1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, "rst_run");
      cyc(1'b0, 1'b0, 1'b0, "rst_run");
      cyc(1'b0, 1'b0, 1'b0, "rst_run");
      push(32'd0, 4, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, "rst_mid");
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, "rst_noresume");
      $display("sweep midreset: %0d checks so far", checks);

      // step=0: one dwell at start then done
      set_cfg(32'd77, 32'd200, 32'd0, 16'd3);
      push(32'd77, 3, 1'b1, 1'b0);
      push(32'd77, 1, 1'b0, 1'b1);
      push(32'd77, 1, 1'b0, 1'b0);
      run_queue("step0", -1);

      // dwell=0 with step=0: single one-cycle hold
      set_cfg(32'd9, 32'd200, 32'd0, 16'd0);
      push(32'd9, 1, 1'b1, 1'b0);
      push(32'd9, 1, 1'b0, 1'b1);
      push(32'd9, 1, 1'b0, 1'b0);
      run_queue("dwell0_step0", -1);

      // dwell=0 treated as 1 cycle per word
      set_cfg(32'd10, 32'd40, 32'd10, 16'd0);
      push(32'd10, 1, 1'b1, 1'b0);
      push(32'd20, 1, 1'b1, 1'b0);
      push(32'd30, 1, 1'b1, 1'b0);
      push(32'd40, 1, 1'b1, 1'b0);
      push(32'd40, 1, 1'b0, 1'b1);
      push(32'd40, 1, 1'b0, 1'b0);
      run_queue("dwell0", -1);

      // start >= stop: hold start for one dwell then done
      set_cfg(32'd300, 32'd100, 32'd50, 16'd1);
      push(32'd300, 1, 1'b1, 1'b0);
      push(32'd300, 1, 1'b0, 1'b1);
      push(32'd300, 1, 1'b0, 1'b0);
      run_queue("empty_range", -1);

      // 10..30 step 10: round trip when bidirectional, up-only otherwise
      set_cfg(32'd10, 32'd30, 32'd10, 16'd1);
      push(32'd10, 1, 1'b1, 1'b0);
      push(32'd20, 1, 1'b1, 1'b0);
      push(32'd30, 1, 1'b1, 1'b0);
`ifdef SWEEP_BIDIR_EN
      push(32'd20, 1, 1'b1, 1'b0);
      push(32'd10, 1, 1'b1, 1'b0);
      push(32'd10, 1, 1'b0, 1'b1);
      push(32'd10, 1, 1'b0, 1'b0);
`else
      push(32'd30, 1, 1'b0, 1'b1);
      push(32'd30, 1, 1'b0, 1'b0);
`endif
      run_queue("direction", -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
